// File: rtl/pearson_hash_sched_if.sv
// Bundle of requester, result, configuration and table-port signals for pearson_hash_sched.
// The slave modport is the scheduler's view. The master modport is the view of the surrounding environment.
interface pearson_hash_sched_if;
    logic [1:0]  req_valid;
    logic [31:0] req_msg0;
    logic [31:0] req_msg1;
    logic [1:0]  req_ready;
    logic        hash_valid;
    logic [7:0]  hash;
    logic        hash_id;
    logic        hash_ready;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic        tbl_re;
    logic [7:0]  tbl_addr;
    logic [7:0]  tbl_rdata;
    logic        tbl_we;
    logic [7:0]  tbl_waddr;
    logic [7:0]  tbl_wdata;

    modport slave (
        input  req_valid, req_msg0, req_msg1, hash_ready,
        input  cfg_we, cfg_addr, cfg_data, tbl_rdata,
        output req_ready, hash_valid, hash, hash_id, cfg_ready,
        output tbl_re, tbl_addr, tbl_we, tbl_waddr, tbl_wdata
    );

    modport master (
        output req_valid, req_msg0, req_msg1, hash_ready,
        output cfg_we, cfg_addr, cfg_data, tbl_rdata,
        input  req_ready, hash_valid, hash, hash_id, cfg_ready,
        input  tbl_re, tbl_addr, tbl_we, tbl_waddr, tbl_wdata
    );
endinterface

// File: rtl/pearson_hash_sched.sv
// Round-robin sequencer for a shared 8-bit Pearson hash datapath with one synchronous table read port.
// Table writes are accepted only while idle, and they take priority over new messages.
module pearson_hash_sched #(
    parameter logic [7:0] SEED = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pearson_hash_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_h, w_h_nxt;
    logic [31:0] r_msg, w_msg_nxt;
    logic        r_id, w_id_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic        r_last, w_last_nxt;

    logic        w_grant_any;
    logic        w_grant_id;
    logic [7:0]  w_byte;

    // On a tie, the requester that was not granted last wins. Otherwise the single valid requester wins.
    always_comb begin
        w_grant_any = |bus.req_valid;
        w_grant_id  = (bus.req_valid == 2'b11) ? ~r_last : bus.req_valid[1];
    end

    assign w_byte = r_msg[{r_idx, 3'b000} +: 8];

    always_comb begin
        // NOTE: each signal gets a default before the case, so no path through the block leaves a latch.
        w_state_nxt   = r_state;
        w_h_nxt       = r_h;
        w_msg_nxt     = r_msg;
        w_id_nxt      = r_id;
        w_idx_nxt     = r_idx;
        w_last_nxt    = r_last;
        bus.req_ready = 2'b00;
        bus.cfg_ready = 1'b0;
        bus.tbl_we    = 1'b0;
        bus.tbl_waddr = 8'h00;
        bus.tbl_wdata = 8'h00;
        bus.tbl_re    = 1'b0;
        bus.tbl_addr  = 8'h00;
        bus.hash_valid = 1'b0;
        bus.hash      = 8'h00;
        bus.hash_id   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_we) begin
                    bus.tbl_we    = 1'b1;
                    bus.tbl_waddr = bus.cfg_addr;
                    bus.tbl_wdata = bus.cfg_data;
                end else if (w_grant_any) begin
                    // The grant goes only to a valid requester, so asserting ready means the message is accepted.
                    bus.req_ready = w_grant_id ? 2'b10 : 2'b01;
                    w_msg_nxt     = w_grant_id ? bus.req_msg1 : bus.req_msg0;
                    w_id_nxt      = w_grant_id;
                    w_last_nxt    = w_grant_id;
                    w_h_nxt       = SEED;
                    w_idx_nxt     = 2'd0;
                    w_state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.tbl_re   = 1'b1;
                bus.tbl_addr = r_h ^ w_byte;
                w_state_nxt  = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_h_nxt = bus.tbl_rdata;
                if (r_idx == 2'd3) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DONE: begin
                bus.hash_valid = 1'b1;
                bus.hash       = r_h;
                bus.hash_id    = r_id;
                if (bus.hash_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples values from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_h     <= 8'h00;
            r_msg   <= 32'h0;
            r_id    <= 1'b0;
            r_idx   <= 2'd0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_msg   <= w_msg_nxt;
            r_id    <= w_id_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule
